// File: rtl/imem_responder.sv
// imem_responder: instruction fetch responder with a preloadable word array and a fixed response latency.
module imem_responder #(
  parameter logic [31:0] BASE = 32'h8000_0000,
  parameter int DEPTH = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_inst,
  output logic        resp_err,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic [31:0] fetch_count
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [32:0] LO = {1'b0, BASE};
  localparam logic [32:0] HI = LO + 33'(4 * DEPTH);
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [3:0] cnt;
  logic [31:0] mem [DEPTH];
  function automatic logic ok(input logic [31:0] a);
    return a[1:0] == 2'b00 && {1'b0, a} >= LO && {1'b0, a} < HI;
  endfunction
  function automatic logic [IW-1:0] idx(input logic [31:0] a);
    return IW'((a - BASE) >> 2);
  endfunction
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  // Loader writes bypass reset so a program image survives a core reset.
  always_ff @(posedge clk)
    if (load_we && ok(load_addr)) mem[idx(load_addr)] <= load_data;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      resp_inst <= '0;
      resp_err <= 1'b0;
      fetch_count <= '0;
    end else if (state == IDLE && req_valid) begin
      resp_err <= !ok(req_addr);
      resp_inst <= ok(req_addr) ? mem[idx(req_addr)] : EBREAK;
      cnt <= '0;
      state <= LATENCY == 1 ? RESP : WAIT;
    end else if (state == WAIT) begin
      cnt <= cnt + 4'd1;
      if (cnt == 4'(LATENCY - 2)) state <= RESP;
    end else if (state == RESP && resp_ready) begin
      state <= IDLE;
      fetch_count <= fetch_count + 32'd1;
    end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed checks of a LATENCY=2 and a LATENCY=1 responder sharing clock, reset and load port.
module tb_imem_responder;
  logic clk = 1'b0, rst = 1'b1;
  logic load_we = 1'b0;
  logic [31:0] load_addr = '0, load_data = '0;
  logic req_valid = 1'b0, resp_ready = 1'b1;
  logic [31:0] req_addr = '0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_inst, fetch_count;
  logic q_valid = 1'b0;
  logic [31:0] q_addr = '0;
  logic q_ready, q_resp_valid, q_err;
  logic [31:0] q_inst, q_count;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  imem_responder #(.LATENCY(2)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst), .resp_err(resp_err),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data), .fetch_count(fetch_count)
  );
  imem_responder #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(q_valid), .req_ready(q_ready), .req_addr(q_addr),
    .resp_valid(q_resp_valid), .resp_ready(1'b1), .resp_inst(q_inst), .resp_err(q_err),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data), .fetch_count(q_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    tick();
    load_we = 1'b0;
  endtask
  task automatic fetch(input logic [31:0] a, input logic [31:0] inst, input logic err, input logic [31:0] cnt);
    req_valid = 1'b1; req_addr = a; resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    check("wait_valid", 32'(resp_valid), 32'd0);
    check("wait_ready", 32'(req_ready), 32'd0);
    tick();
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_inst", resp_inst, inst);
    check("resp_err", 32'(resp_err), 32'(err));
    tick();
    check("done_valid", 32'(resp_valid), 32'd0);
    check("done_ready", 32'(req_ready), 32'd1);
    check("fetch_count", fetch_count, cnt);
  endtask
  initial begin
    tick();
    rst = 1'b0;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_inst", resp_inst, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_count", fetch_count, 32'd0);
    load(32'h8000_0000, 32'h0000_0413);
    load(32'h8000_0004, 32'h0010_0073);
    load(32'h8000_0010, 32'h1234_5678);
    load(32'h8000_0FFC, 32'hCAFE_F00D);
    load(32'h8000_0005, 32'hBAD0_BAD0);
    load(32'h7FFF_FFFC, 32'hBAD1_BAD1);
    fetch(32'h8000_0000, 32'h0000_0413, 1'b0, 32'd1);
    fetch(32'h8000_0002, 32'h0010_0073, 1'b1, 32'd2);
    fetch(32'h7FFF_FFFC, 32'h0010_0073, 1'b1, 32'd3);
    fetch(32'h8000_1000, 32'h0010_0073, 1'b1, 32'd4);
    fetch(32'h8000_0FFC, 32'hCAFE_F00D, 1'b0, 32'd5);
    fetch(32'h8000_0004, 32'h0010_0073, 1'b0, 32'd6);
    // Stall the response while a second request keeps knocking.
    req_valid = 1'b1; req_addr = 32'h8000_0000; resp_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(resp_valid), 32'd1);
      check("stall_ready", 32'(req_ready), 32'd0);
      check("stall_inst", resp_inst, 32'h0000_0413);
      check("stall_count", fetch_count, 32'd6);
      tick();
    end
    resp_ready = 1'b1; req_valid = 1'b0;
    tick();
    check("stall_done_valid", 32'(resp_valid), 32'd0);
    check("stall_done_count", fetch_count, 32'd7);
    req_valid = 1'b1; req_addr = 32'h8000_0010;
    load_we = 1'b1; load_addr = 32'h8000_0010; load_data = 32'hDEAD_BEEF;
    tick();
    req_valid = 1'b0; load_we = 1'b0;
    tick();
    check("rbw_old", resp_inst, 32'h1234_5678);
    tick();
    fetch(32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 32'd9);
    req_valid = 1'b1; req_addr = 32'h8000_0000;
    tick();
    req_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wrst_valid", 32'(resp_valid), 32'd0);
    check("wrst_ready", 32'(req_ready), 32'd1);
    check("wrst_count", fetch_count, 32'd0);
    tick();
    check("wrst_nopulse", 32'(resp_valid), 32'd0);
    fetch(32'h8000_0000, 32'h0000_0413, 1'b0, 32'd1);
    q_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q_addr = i[0] ? 32'h8000_0004 : 32'h8000_0000;
      tick();
      check("l1_valid", 32'(q_resp_valid), 32'd1);
      check("l1_ready", 32'(q_ready), 32'd0);
      check("l1_inst", q_inst, i[0] ? 32'h0010_0073 : 32'h0000_0413);
      tick();
      check("l1_done_valid", 32'(q_resp_valid), 32'd0);
      check("l1_done_ready", 32'(q_ready), 32'd1);
      check("l1_count", q_count, 32'(i + 1));
    end
    q_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: serves the fetch side of the RV32 core, which issues a PC and consumes a 32-bit instruction.
- Accepts one fetch request at a time over a valid/ready handshake and returns the word after a programmable latency.
- Word storage is backed by an internal array. A side load port lets the bench or loader preload program images.
- Memory window starts at 0x80000000, which matches the core reset PC.

Parameters:
- BASE, 32'h80000000, byte address of word 0.
- DEPTH, 1024, number of 32-bit words; must be a power of two.
- LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
- clk  in  1  clock; all logic updates on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  fetch byte address (PC).
- resp_valid  out  1  response word available.
- resp_ready  in  1  requester consumes the response.
- resp_inst  out  32  instruction word.
- resp_err  out  1  request was misaligned or out of window.
- load_we  in  1  preload write enable.
- load_addr  in  32  preload byte address; must be word aligned and in window, otherwise ignored.
- load_data  in  32  preload word.
- fetch_count  out  32  number of completed response handshakes.

Behaviour:
- States:
  - IDLE: req_ready=1.
  - WAIT: counting latency.
  - RESP: resp_valid=1.
- Reset, applied on the clock edge where rst=1:
  - state goes to IDLE; latency counter goes to 0.
  - req_ready=1, resp_valid=0, resp_inst=0, resp_err=0, fetch_count=0.
  - Array contents are not reset.
- Acceptance:
  - A request is accepted in IDLE on a cycle with req_valid=1.
  - In the same edge the responder captures resp_inst and resp_err (computed from req_addr) into holding registers and leaves IDLE.
- Latency:
  - LATENCY=1: IDLE goes to RESP directly, so resp_valid is high on the cycle after acceptance.
  - LATENCY=N>1: the block spends N-1 cycles in WAIT, then enters RESP. resp_valid rises exactly N cycles after the acceptance edge.
- req_ready is 0 in WAIT and RESP. No request is accepted while a response is outstanding; a new request may be accepted only once the block is back in IDLE.
- RESP:
  - resp_valid, resp_inst and resp_err stay stable until resp_ready=1 is sampled.
  - On that edge: go to IDLE, resp_valid goes to 0, fetch_count increments (wraps at 2^32).
- Error rules:
  - Error if req_addr[1:0] != 0, or if req_addr < BASE, or if req_addr >= BASE + 4*DEPTH.
  - On error: resp_err=1 and resp_inst=32'h00100073 (ebreak), so the core halts cleanly.
  - Otherwise resp_err=0 and resp_inst = array[(req_addr-BASE)>>2].
- Load port:
  - A write occurs on any edge with load_we=1 and a valid load_addr, independent of state and of rst.
  - A load and an accepted request to the same word on the same edge: the response returns the OLD word (read-before-write).
  - Loads after acceptance do not alter the held response.
- Reset while in WAIT or RESP: the pending response is dropped (never presented). fetch_count clears. The next request is accepted normally.
- Width rules:
  - Window compare uses 33-bit arithmetic so that BASE + 4*DEPTH does not overflow.
  - Index width is log2(DEPTH).

Test Plan:
- Preload word 0 = 0x00000413 and word 1 = 0x00100073. Request 0x80000000 with LATENCY=2 and resp_ready held at 1 -> resp_valid high exactly 2 cycles after acceptance, resp_inst=0x00000413, resp_err=0, fetch_count=1.
- Request 0x80000002 -> resp_err=1, resp_inst=0x00100073. Request 0x7FFFFFFC, then request 0x80001000 (DEPTH=1024) -> both give resp_err=1.
- Hold resp_ready=0 for 5 cycles after resp_valid, with req_valid held high the whole time -> req_ready stays 0, resp fields stay stable, and only one handshake is counted when resp_ready rises.
- On the same edge, load 0xDEADBEEF at 0x80000010 and accept a request to 0x80000010, where the old word is 0x12345678 -> response gives 0x12345678. A following fetch of the same address gives 0xDEADBEEF.
- Assert rst for 1 cycle while in WAIT -> no resp_valid pulse, fetch_count=0, req_ready=1 on the next cycle. The array keeps its preloaded data.
- Build with LATENCY=1: issue back-to-back requests with resp_ready=1 -> each response appears 1 cycle after acceptance, and acceptances occur every 2 cycles.
